bool_sweep_checker: RTL and testbench

- Hardware response-side counterpart to the team's exhaustive Boolean-function stimulus flow.
- Sequences every input vector 0..2^N_IN-1 into the function under test, waits a settle interval, then samples its dataflow, behavioural and structural outputs.
- Flags disagreement among the three outputs, captures the full truth table of the dataflow output, and reports a pass/fail verdict through a start/busy/done handshake.
- Sits beside the bool_q* implementations on-chip and replaces the printed truth-table comparison.

---
 rtl/bool_sweep_checker.sv | 127 ++++++++++++
 tb/tb_bool_sweep_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bool_sweep_checker.sv
// bool_sweep_checker: sweeps all input vectors of a Boolean function and compares
// its dataflow, behavioural and structural outputs, capturing the truth table.
// Ports:
//   clk, rst (async, active-high), start (accepted in IDLE/DONE)
//   f_d, f_b, f_s        : outputs of the three implementations under test
//   vec_out              : vector driven to all implementations (MSB = first input)
//   busy, done, pass     : handshake and verdict
//   mism_count           : vectors with any disagreement
//   first_fail_valid/vec : lowest mismatching vector
//   truth_table          : bit i = sampled f_d at vector i
module bool_sweep_checker #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 f_d,
   input  logic                 f_b,
   input  logic                 f_s,
   output logic [N_IN-1:0]      vec_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        mism_count,
   output logic                 first_fail_valid,
   output logic [N_IN-1:0]      first_fail_vec,
   output logic [2**N_IN-1:0]   truth_table
);
   localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_IN-1:0]    vec_q, vec_d;
   logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [N_IN:0]      mism_q, mism_d;
   logic               ffv_q, ffv_d;
   logic [N_IN-1:0]    ffvec_q, ffvec_d;
   logic [2**N_IN-1:0] tt_q, tt_d;
   logic               sample, mism;

   assign sample = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
   assign mism   = (f_d != f_b) || (f_d != f_s);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      mism_d  = mism_q;
      ffv_d   = ffv_q;
      ffvec_d = ffvec_q;
      tt_d    = tt_q;
      if (start && state_q != S_WAIT) begin
         state_d = S_WAIT;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         pass_d  = 1'b0;
         vec_d   = '0;
         cnt_d   = '0;
         mism_d  = '0;
         ffv_d   = 1'b0;
         ffvec_d = '0;
         tt_d    = '0;
      end else if (state_q == S_WAIT && !sample) begin
         cnt_d = cnt_q + 1'b1;
      end else if (sample) begin
         tt_d[vec_q] = f_d;
         mism_d      = mism_q + (N_IN+1)'(mism);
         if (mism && !ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
         end
         // the last vector's own sample is folded into the verdict
         if (&vec_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mism_d == '0);
         end else begin
            vec_d = vec_q + 1'b1;
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mism_q  <= '0;
         ffv_q   <= 1'b0;
         ffvec_q <= '0;
         tt_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mism_q  <= mism_d;
         ffv_q   <= ffv_d;
         ffvec_q <= ffvec_d;
         tt_q    <= tt_d;
      end
   end

   assign vec_out          = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign mism_count       = mism_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;
   assign truth_table      = tt_q;
endmodule

// File: tb/tb_bool_sweep_checker.sv
// tb_bool_sweep_checker: randomized and directed checks of bool_sweep_checker.
module tb_bool_sweep_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   logic       start3 = 1'b0, fd3, fb3, fs3, busy3, done3, pass3, ffv3;
   logic [2:0] vec3, ffvec3;
   logic [3:0] mc3;
   logic [7:0] tt3;
   logic [7:0] td3 = '0, tbt3 = '0, tst3 = '0;

   logic        start4 = 1'b0, fd4, fb4, fs4, busy4, done4, pass4, ffv4;
   logic [3:0]  vec4, ffvec4;
   logic [4:0]  mc4;
   logic [15:0] tt4;
   logic [15:0] td4 = '0, tbt4 = '0, tst4 = '0;

   always #5 clk = ~clk;

   assign fd3 = td3[vec3];
   assign fb3 = tbt3[vec3];
   assign fs3 = tst3[vec3];
   assign fd4 = td4[vec4];
   assign fb4 = tbt4[vec4];
   assign fs4 = tst4[vec4];

   bool_sweep_checker #(.N_IN(3), .SETTLE(2)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .f_d(fd3), .f_b(fb3), .f_s(fs3),
      .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3), .mism_count(mc3),
      .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .truth_table(tt3));

   bool_sweep_checker #(.N_IN(4), .SETTLE(1)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .f_d(fd4), .f_b(fb4), .f_s(fs4),
      .vec_out(vec4), .busy(busy4), .done(done4), .pass(pass4), .mism_count(mc4),
      .first_fail_valid(ffv4), .first_fail_vec(ffvec4), .truth_table(tt4));

   // Reference: walk the tables vector by vector and tally disagreements.
   task automatic model(input logic [15:0] d, input logic [15:0] b, input logic [15:0] s, input int nv,
                        output logic [15:0] tt, output int mc, output logic ffv, output int fv);
      tt = '0; mc = 0; ffv = 1'b0; fv = 0;
      for (int v = 0; v < nv; v++) begin
         tt[v] = d[v];
         if (d[v] != b[v] || d[v] != s[v]) begin
            mc++;
            if (!ffv) begin ffv = 1'b1; fv = v; end
         end
      end
   endtask

   task automatic sweep3(input bit dup, output int lat, output bit acc_ok, output bit busy_ok);
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      acc_ok = busy3 && !done3 && !pass3 && mc3 == 0 && !ffv3 && ffvec3 == 0 && tt3 == 0 && vec3 == 0;
      lat = 0; busy_ok = 1'b1;
      while (!done3 && lat < 200) begin
         start3 = dup && vec3 == 3'd3;
         @(negedge clk); lat++;
         if (!done3 && !busy3) busy_ok = 1'b0;
      end
      start3 = 1'b0;
   endtask

   task automatic sweep4(output int lat, output bit acc_ok);
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      acc_ok = busy4 && !done4 && !pass4 && mc4 == 0 && !ffv4 && ffvec4 == 0 && tt4 == 0 && vec4 == 0;
      lat = 0;
      while (!done4 && lat < 200) begin
         @(negedge clk); lat++;
      end
   endtask

   task automatic test_reset;
      td3 = 8'($urandom); tbt3 = 8'($urandom); tst3 = 8'($urandom);
      #2;
      total++; if ({vec3, busy3, done3, pass3, mc3, ffv3, ffvec3, tt3} !== '0) begin bad++; $display("FAIL reset3 got=%h exp=0", {vec3, busy3, done3, pass3, mc3, ffv3, ffvec3, tt3}); end
      total++; if ({vec4, busy4, done4, pass4, mc4, ffv4, ffvec4, tt4} !== '0) begin bad++; $display("FAIL reset4 got=%h exp=0", {vec4, busy4, done4, pass4, mc4, ffv4, ffvec4, tt4}); end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(negedge clk);
      total++; if ({busy3, done3, vec3} !== '0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", {busy3, done3, vec3}); end
   endtask

   task automatic test_sweep_basic;
      int lat; bit a, bo;
      td3 = 8'hCA; tbt3 = 8'hCA; tst3 = 8'hCA;
      sweep3(1'b0, lat, a, bo);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL basic_accept got=%0d exp=1", a); end
      total++; if (bo !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0d exp=1", bo); end
      total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d exp=16", lat); end
      total++; if (tt3 !== 8'hCA) begin bad++; $display("FAIL basic_tt got=%h exp=ca", tt3); end
      total++; if ({pass3, mc3, ffv3, busy3} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin bad++; $display("FAIL basic_verdict got=%b exp=1000000", {pass3, mc3, ffv3, busy3}); end
      td3 = 8'($urandom); tbt3 = 8'($urandom); tst3 = 8'($urandom);
      repeat (3) @(negedge clk);
      total++; if ({done3, vec3, tt3, pass3} !== {1'b1, 3'd7, 8'hCA, 1'b1}) begin bad++; $display("FAIL done_hold got=%h exp=%h", {done3, vec3, tt3, pass3}, {1'b1, 3'd7, 8'hCA, 1'b1}); end
      td3 = 8'h65; tbt3 = 8'h65; tst3 = 8'h65;
      sweep3(1'b0, lat, a, bo);
      total++; if ({tt3, pass3} !== {8'h65, 1'b1}) begin bad++; $display("FAIL sigma_tt got=%h exp=%h", {tt3, pass3}, {8'h65, 1'b1}); end
   endtask

   task automatic test_stuck_fs;
      int lat; bit a, bo;
      td3 = 8'hCA; tbt3 = 8'hCA; tst3 = 8'h00;
      sweep3(1'b0, lat, a, bo);
      total++; if (mc3 !== 4'd4) begin bad++; $display("FAIL stuck_count got=%0d exp=4", mc3); end
      total++; if ({ffv3, ffvec3, pass3} !== {1'b1, 3'd1, 1'b0}) begin bad++; $display("FAIL stuck_first got=%b exp=10010", {ffv3, ffvec3, pass3}); end
      total++; if (tt3 !== 8'hCA) begin bad++; $display("FAIL stuck_tt got=%h exp=ca", tt3); end
   endtask

   task automatic test_restart_from_done;
      int lat; bit a, bo;
      td3 = 8'hCA; tbt3 = 8'hCA; tst3 = 8'hCA;
      sweep3(1'b0, lat, a, bo);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL restart_cleared got=%0d exp=1", a); end
      total++; if ({pass3, mc3, ffv3, ffvec3, lat} !== {1'b1, 4'd0, 1'b0, 3'd0, 16}) begin bad++; $display("FAIL restart_clean pass=%b mc=%0d ffv=%b lat=%0d exp pass=1 mc=0 ffv=0 lat=16", pass3, mc3, ffv3, lat); end
   endtask

   task automatic test_start_in_wait;
      int lat; bit a, bo;
      td3 = 8'hCA; tbt3 = 8'hCA; tst3 = 8'h00;
      sweep3(1'b1, lat, a, bo);
      total++; if (lat !== 16) begin bad++; $display("FAIL dup_latency got=%0d exp=16", lat); end
      total++; if ({mc3, ffvec3, tt3, pass3} !== {4'd4, 3'd1, 8'hCA, 1'b0}) begin bad++; $display("FAIL dup_results got=%h exp=%h", {mc3, ffvec3, tt3, pass3}, {4'd4, 3'd1, 8'hCA, 1'b0}); end
   endtask

   task automatic test_q4;
      int lat; bit a;
      td4 = 16'($urandom); tbt4 = td4 ^ 16'h0400; tst4 = td4;
      sweep4(lat, a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL q4_accept got=%0d exp=1", a); end
      total++; if (lat !== 16) begin bad++; $display("FAIL q4_latency got=%0d exp=16", lat); end
      total++; if ({mc4, ffv4, ffvec4, pass4} !== {5'd1, 1'b1, 4'hA, 1'b0}) begin bad++; $display("FAIL q4_verdict got=%h exp=%h", {mc4, ffv4, ffvec4, pass4}, {5'd1, 1'b1, 4'hA, 1'b0}); end
      total++; if (tt4 !== td4) begin bad++; $display("FAIL q4_tt got=%h exp=%h", tt4, td4); end
   endtask

   task automatic test_rst_mid;
      int w = 0;
      td3 = 8'hCA; tbt3 = 8'hCA; tst3 = 8'h00;
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      while (vec3 != 3'd5 && w < 50) begin @(negedge clk); w++; end
      total++; if (vec3 !== 3'd5) begin bad++; $display("FAIL rst_mid_reach got=%0d exp=5", vec3); end
      rst = 1'b1;
      #1;
      total++; if ({vec3, busy3, done3, pass3, mc3, ffv3, ffvec3, tt3} !== '0) begin bad++; $display("FAIL rst_mid_clear got=%h exp=0", {vec3, busy3, done3, pass3, mc3, ffv3, ffvec3, tt3}); end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({busy3, done3, vec3, tt3} !== '0) begin bad++; $display("FAIL rst_mid_idle got=%h exp=0", {busy3, done3, vec3, tt3}); end
   endtask

   task automatic test_random;
      int lat, emc, efv; bit a, bo; logic [15:0] ett; logic effv;
      for (int i = 0; i < 8; i++) begin
         td3 = 8'($urandom);
         tbt3 = td3 ^ 8'($urandom & $urandom & $urandom);
         tst3 = td3 ^ 8'($urandom & $urandom & $urandom);
         model({8'h0, td3}, {8'h0, tbt3}, {8'h0, tst3}, 8, ett, emc, effv, efv);
         sweep3(1'b0, lat, a, bo);
         total++; if ({tt3, mc3, ffv3, ffvec3, pass3, lat} !== {ett[7:0], 4'(emc), effv, 3'(efv), emc == 0, 16}) begin bad++; $display("FAIL rand3_%0d tt=%h mc=%0d ffv=%b fv=%0d pass=%b lat=%0d exp tt=%h mc=%0d ffv=%b fv=%0d lat=16", i, tt3, mc3, ffv3, ffvec3, pass3, lat, ett[7:0], emc, effv, efv); end
      end
      for (int i = 0; i < 6; i++) begin
         td4 = 16'($urandom);
         tbt4 = td4 ^ 16'($urandom & $urandom & $urandom);
         tst4 = (i == 0) ? td4 : td4 ^ 16'($urandom & $urandom & $urandom);
         if (i == 0) tbt4 = td4;
         model(td4, tbt4, tst4, 16, ett, emc, effv, efv);
         sweep4(lat, a);
         total++; if ({tt4, mc4, ffv4, ffvec4, pass4, lat} !== {ett, 5'(emc), effv, 4'(efv), emc == 0, 16}) begin bad++; $display("FAIL rand4_%0d tt=%h mc=%0d ffv=%b fv=%0d pass=%b lat=%0d exp tt=%h mc=%0d ffv=%b fv=%0d lat=16", i, tt4, mc4, ffv4, ffvec4, pass4, lat, ett, emc, effv, efv); end
      end
   endtask

   initial begin
      test_reset;
      test_sweep_basic;
      test_stuck_fs;
      test_restart_from_done;
      test_start_in_wait;
      test_q4;
      test_rst_mid;
      test_stuck_fs;
      test_restart_from_done;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
